data_memory_ctrl: RTL and testbench

- Parametrised successor to the CPU's byte-addressed 64-bit data memory.
- Adds a request/response handshake, configurable wait-state latency, and byte/half/word/double access sizes.
- Adds sign/zero extension of loads, plus error reporting for misaligned and out-of-range accesses.
- Sits between the MEM pipeline stage and the byte-array storage. Little-endian.

---
 rtl/data_memory_pkg.sv | 27 ++
 rtl/data_memory_ctrl_if.sv | 33 +++
 rtl/data_memory_ctrl_load_extend.sv | 28 ++
 rtl/data_memory_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_pkg
// Purpose  : Shared access-size encodings, FSM state type and helpers for the
//            data memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] access_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl_if
// Purpose  : Request/response bus between the MEM stage (master) and the
//            data memory controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  request;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [1:0]            access_size;
    logic                  sign_extend;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  ready;
    logic                  response_valid;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  error;

    modport master (
        output request, write, address, access_size, sign_extend, write_data,
        input  ready, response_valid, read_data, error
    );

    modport slave (
        input  request, write, address, access_size, sign_extend, write_data,
        output ready, response_valid, read_data, error
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Sign/zero extension of a little-endian load gather to 64 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import data_memory_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  access_size,
    input  logic        sign_extend,
    output logic [63:0] result
);

    // Keep the low 8n bits, fill the rest with the sign bit or zeros.
    always_comb begin
        result = raw;
        case (access_size)
            SIZE_BYTE: result = {{56{sign_extend & raw[7]}},  raw[7:0]};
            SIZE_HALF: result = {{48{sign_extend & raw[15]}}, raw[15:0]};
            SIZE_WORD: result = {{32{sign_extend & raw[31]}}, raw[31:0]};
            default:   result = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Purpose  : Byte-addressed little-endian data memory with request/response
//            handshake, configurable wait states, sized accesses, load
//            extension and misalignment / range error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int SIZE        = 256,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    data_memory_ctrl_if.slave bus
);

    localparam int         IDX_W     = $clog2(SIZE);
    localparam int         AW1       = ADDR_WIDTH + 1;
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state;
    state_t next_state;
    logic [3:0] count;
    logic [3:0] next_count;
    logic       accept;
    logic       commit;

    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_address;
    logic [1:0]            lat_size;
    logic                  lat_sext;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  op_write;
    logic [ADDR_WIDTH-1:0] op_address;
    logic [1:0]            op_size;
    logic                  op_sext;
    logic [DATA_WIDTH-1:0] op_wdata;

    logic [3:0]  bytes;
    logic [AW1-1:0] end_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        access_error;
    logic [IDX_W-1:0] byte_idx [8];
    logic [63:0] raw_gather;
    logic [63:0] extended;

    logic [DATA_WIDTH-1:0] load_result;
    logic                  error_flag;

    logic [7:0] mem [SIZE];

    // State and wait-counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic; commit marks the edge entering RESPOND.
    always_comb begin
        next_state = state;
        next_count = count;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.request) begin
                    accept = 1'b1;
                    if (HAS_WAIT) begin
                        next_state = WAIT;
                        next_count = WAIT_INIT;
                    end else begin
                        next_state = RESPOND;
                        commit     = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    next_state = RESPOND;
                    commit     = 1'b1;
                end else begin
                    next_count = count - 4'd1;
                end
            end
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request fields on the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_size    <= SIZE_BYTE;
            lat_sext    <= 1'b0;
            lat_wdata   <= '0;
        end else if (accept) begin
            lat_write   <= bus.write;
            lat_address <= bus.address;
            lat_size    <= bus.access_size;
            lat_sext    <= bus.sign_extend;
            lat_wdata   <= bus.write_data;
        end
    end

    // With zero wait states the commit happens on the accept edge, so the
    // operation must come straight from the bus rather than the latches.
    always_comb begin
        op_write   = lat_write;
        op_address = lat_address;
        op_size    = lat_size;
        op_sext    = lat_sext;
        op_wdata   = lat_wdata;
        if (state == IDLE) begin
            op_write   = bus.write;
            op_address = bus.address;
            op_size    = bus.access_size;
            op_sext    = bus.sign_extend;
            op_wdata   = bus.write_data;
        end
    end

    // Alignment and range check on the full-width address, no wrap-around.
    always_comb begin
        bytes        = access_bytes(op_size);
        end_addr     = {1'b0, op_address} + AW1'(bytes);
        misaligned   = (op_address[2:0] & 3'(bytes - 4'd1)) != 3'd0;
        out_of_range = end_addr > AW1'(SIZE);
        access_error = misaligned | out_of_range;
    end

    // Byte indices wrap inside the array so the gather never indexes out of
    // bounds; wrapped bytes are only seen on accesses already flagged as errors.
    always_comb begin
        raw_gather = 64'd0;
        for (int i = 0; i < 8; i++) begin
            byte_idx[i]          = op_address[IDX_W-1:0] + IDX_W'(i);
            raw_gather[8*i +: 8] = mem[byte_idx[i]];
        end
    end

    load_extend u_load_extend (
        .raw         (raw_gather),
        .access_size (op_size),
        .sign_extend (op_sext),
        .result      (extended)
    );

    // Storage write on a successful store commit; contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && commit && op_write && !access_error) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < bytes) begin
                    mem[byte_idx[i]] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response data and error, held until the next commit or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_result <= '0;
            error_flag  <= 1'b0;
        end else if (commit) begin
            if (access_error) begin
                load_result <= '0;
                error_flag  <= 1'b1;
            end else if (op_write) begin
                load_result <= '0;
                error_flag  <= 1'b0;
            end else begin
                load_result <= extended;
                error_flag  <= 1'b0;
            end
        end
    end

    assign bus.ready          = (state == IDLE);
    assign bus.response_valid = (state == RESPOND);
    assign bus.read_data      = load_result;
    assign bus.error          = error_flag;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Purpose  : Self-checking bench for data_memory_ctrl (vector table, corner
//            sequences, randomized traffic against a byte-array model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

    localparam int MEM_SIZE = 256;
    localparam int WAITS    = 1;
    localparam int LAT      = 1 + WAITS;

    logic clock = 1'b0;
    logic reset = 1'b1;

    data_memory_ctrl_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    data_memory_ctrl #(
        .SIZE        (MEM_SIZE),
        .ADDR_WIDTH  (64),
        .DATA_WIDTH  (64),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_mem [MEM_SIZE];

    typedef struct {
        logic        w;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: sizes, alignment and range from plain arithmetic on a byte array.
    task automatic model_access(input logic w, input logic [63:0] addr, input logic [1:0] size,
                                input logic sext, input logic [63:0] wdata,
                                output logic [63:0] rd, output logic er);
        int n;
        logic [64:0] last;
        logic [63:0] v;
        n    = 1 << size;
        last = {1'b0, addr} + 65'(n);
        er   = ((addr % 64'(n)) != 0) || (last > 65'(MEM_SIZE));
        rd   = 64'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v = v | (64'(model_mem[int'(addr) + i]) << (8*i));
                if (n < 8 && sext && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
                rd = v;
            end
        end
    endtask

    // One DUT transaction, starting and ending on a falling edge.
    task automatic run_access(input logic w, input logic [63:0] addr, input logic [1:0] size,
                              input logic sext, input logic [63:0] wdata,
                              output logic [63:0] rd, output logic er, output int lat);
        int t;
        t = 0;
        while (!bus.ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!bus.ready) chk("ready_timeout", 64'(bus.ready), 64'd1);
        bus.request     = 1'b1;
        bus.write       = w;
        bus.address     = addr;
        bus.access_size = size;
        bus.sign_extend = sext;
        bus.write_data  = wdata;
        @(posedge clock);
        @(negedge clock);
        bus.request = 1'b0;
        lat = 1;
        while (!bus.response_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        if (!bus.response_valid) begin
            chk("response_timeout", 64'(bus.response_valid), 64'd1);
            lat = -1;
        end
        rd = bus.read_data;
        er = bus.error;
        @(negedge clock);
        chk("pulse_width", 64'(bus.response_valid), 64'd0);
        chk("ready_after", 64'(bus.ready), 64'd1);
        chk("hold_data", bus.read_data, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, pulses;
        logic        w;
        logic [63:0] addr, wd;
        logic [1:0]  sz;
        logic        sx;

        tbl[0]  = '{1'b1, 64'd8,   2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0,                1'b0};
        tbl[1]  = '{1'b0, 64'd8,   2'd3, 1'b0, 64'h0,                64'h0123456789ABCDEF, 1'b0};
        tbl[2]  = '{1'b0, 64'd15,  2'd0, 1'b0, 64'h0,                64'h0000000000000001, 1'b0};
        tbl[3]  = '{1'b0, 64'd8,   2'd1, 1'b1, 64'h0,                64'hFFFFFFFFFFFFCDEF, 1'b0};
        tbl[4]  = '{1'b0, 64'd12,  2'd2, 1'b1, 64'h0,                64'h0000000001234567, 1'b0};
        tbl[5]  = '{1'b1, 64'd0,   2'd3, 1'b0, 64'h1122334455667788, 64'h0,                1'b0};
        tbl[6]  = '{1'b1, 64'd3,   2'd1, 1'b0, 64'h000000000000BEEF, 64'h0,                1'b1};
        tbl[7]  = '{1'b0, 64'd0,   2'd3, 1'b0, 64'h0,                64'h1122334455667788, 1'b0};
        tbl[8]  = '{1'b0, 64'd252, 2'd3, 1'b0, 64'h0,                64'h0,                1'b1};
        tbl[9]  = '{1'b1, 64'd252, 2'd2, 1'b0, 64'h00000000CAFEF00D, 64'h0,                1'b0};
        tbl[10] = '{1'b0, 64'd252, 2'd2, 1'b0, 64'h0,                64'h00000000CAFEF00D, 1'b0};
        tbl[11] = '{1'b0, 64'd252, 2'd2, 1'b1, 64'h0,                64'hFFFFFFFFCAFEF00D, 1'b0};
        tbl[12] = '{1'b0, 64'hFFFFFFFFFFFFFFF8, 2'd3, 1'b0, 64'h0,   64'h0,                1'b1};
        tbl[13] = '{1'b1, 64'd255, 2'd0, 1'b0, 64'h00000000000000A5, 64'h0,                1'b0};
        tbl[14] = '{1'b0, 64'd255, 2'd0, 1'b1, 64'h0,                64'hFFFFFFFFFFFFFFA5, 1'b0};
        tbl[15] = '{1'b0, 64'd254, 2'd1, 1'b0, 64'h0,                64'h000000000000A5FE, 1'b0};
        tbl[16] = '{1'b0, 64'd255, 2'd1, 1'b0, 64'h0,                64'h0,                1'b1};

        bus.request     = 1'b0;
        bus.write       = 1'b0;
        bus.address     = 64'd0;
        bus.access_size = 2'd0;
        bus.sign_extend = 1'b0;
        bus.write_data  = 64'd0;

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_rvalid", 64'(bus.response_valid), 64'd0);
        chk("reset_rdata", bus.read_data, 64'd0);
        chk("reset_error", 64'(bus.error), 64'd0);

        // Give every byte a known value.
        for (int a = 0; a < MEM_SIZE; a += 8) begin
            wd = {$urandom, $urandom};
            model_access(1'b1, 64'(a), 2'd3, 1'b0, wd, exp_rd, exp_er);
            run_access(1'b1, 64'(a), 2'd3, 1'b0, wd, rd, er, lat);
        end

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            model_access(tbl[i].w, tbl[i].addr, tbl[i].size, tbl[i].sext, tbl[i].wdata, exp_rd, exp_er);
            run_access(tbl[i].w, tbl[i].addr, tbl[i].size, tbl[i].sext, tbl[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_error", i), 64'(er), 64'(tbl[i].exp_er));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
        end

        // Requests held high during WAIT must be ignored.
        while (!bus.ready) @(negedge clock);
        model_access(1'b0, 64'd8, 2'd3, 1'b0, 64'd0, exp_rd, exp_er);
        bus.request     = 1'b1;
        bus.write       = 1'b0;
        bus.address     = 64'd8;
        bus.access_size = 2'd3;
        bus.sign_extend = 1'b0;
        @(posedge clock);
        pulses = 0;
        rd     = 64'd0;
        for (int c = 1; c <= WAITS + 6; c++) begin
            @(negedge clock);
            if (bus.response_valid) begin
                pulses++;
                rd = bus.read_data;
            end
            if (c <= WAITS) begin
                bus.request    = 1'b1;
                bus.write      = 1'b1;
                bus.address    = 64'd0;
                bus.write_data = 64'hFFFFFFFFFFFFFFFF;
            end else begin
                bus.request = 1'b0;
            end
        end
        chk("wait_req_pulses", 64'(pulses), 64'd1);
        chk("wait_req_rdata", rd, exp_rd);
        model_access(1'b0, 64'd0, 2'd3, 1'b0, 64'd0, exp_rd, exp_er);
        run_access(1'b0, 64'd0, 2'd3, 1'b0, 64'd0, rd, er, lat);
        chk("wait_req_no_store", rd, exp_rd);

        // Reset during WAIT aborts a store.
        while (!bus.ready) @(negedge clock);
        bus.request     = 1'b1;
        bus.write       = 1'b1;
        bus.address     = 64'd16;
        bus.access_size = 2'd3;
        bus.write_data  = 64'hDEADBEEFDEADBEEF;
        @(posedge clock);
        @(negedge clock);
        bus.request = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.response_valid) pulses++;
            @(negedge clock);
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_rdata", bus.read_data, 64'd0);
        model_access(1'b0, 64'd16, 2'd3, 1'b0, 64'd0, exp_rd, exp_er);
        run_access(1'b0, 64'd16, 2'd3, 1'b0, 64'd0, rd, er, lat);
        chk("abort_old_data", rd, exp_rd);

        // Reset in RESPOND drops response_valid the next cycle.
        while (!bus.ready) @(negedge clock);
        bus.request = 1'b1;
        bus.write   = 1'b0;
        bus.address = 64'd24;
        @(posedge clock);
        @(negedge clock);
        bus.request = 1'b0;
        lat = 0;
        while (!bus.response_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        chk("respond_seen", 64'(bus.response_valid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("respond_reset_drop", 64'(bus.response_valid), 64'd0);
        chk("respond_reset_error", 64'(bus.error), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            w    = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sx   = 1'($urandom_range(0, 1));
            wd   = {$urandom, $urandom};
            addr = 64'($urandom_range(0, MEM_SIZE + 7));
            if ($urandom_range(0, 19) == 0) addr = {$urandom, $urandom};
            model_access(w, addr, sz, sx, wd, exp_rd, exp_er);
            run_access(w, addr, sz, sx, wd, rd, er, lat);
            chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rand%0d_error", i), 64'(er), 64'(exp_er));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(LAT));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
